// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark embedder.
package wm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEmbed,
        StDrain
    } wm_state_e;

    localparam logic WM_MODE_1LSB = 1'b0;
    localparam logic WM_MODE_2LSB = 1'b1;

    localparam int unsigned WM_PIX_W = 8;
    localparam int unsigned WM_IMG_W = 256;
    localparam int unsigned WM_IMG_H = 256;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wm_embed_if.sv
// Pixel stream and watermark-generator handshake bundle.
// master: the embedder side; slave: the surrounding source/sink/generator.
interface wm_embed_if
    import wm_pkg::*;
#(
    parameter int unsigned PIX_W = WM_PIX_W
) ();

    logic             pix_in_valid;
    logic             pix_in_ready;
    logic [PIX_W-1:0] pix_in;
    logic             pix_out_valid;
    logic             pix_out_ready;
    logic [PIX_W-1:0] pix_out;
    logic [1:0]       wm_data;
    logic             wm_advance;

    modport master (
        input  pix_in_valid, pix_in, pix_out_ready, wm_data,
        output pix_in_ready, pix_out_valid, pix_out, wm_advance
    );

    modport slave (
        output pix_in_valid, pix_in, pix_out_ready, wm_data,
        input  pix_in_ready, pix_out_valid, pix_out, wm_advance
    );

endinterface

// File: rtl/wm_raster_cnt.sv
// Raster column/row counter with last-pixel and ROI-hit flags.
// WM_ROI_EN: when defined, roi_hit reflects the ROI window; otherwise it is
// always 1.
module wm_raster_cnt
    import wm_pkg::*;
#(
    parameter int unsigned IMG_W  = WM_IMG_W,
    parameter int unsigned IMG_H  = WM_IMG_H,
    parameter int          ROI_X0 = 0,
    parameter int          ROI_X1 = 255,
    parameter int          ROI_Y0 = 0,
    parameter int          ROI_Y1 = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    output logic last,
    output logic roi_hit
);

    localparam int unsigned CW = cnt_width(IMG_W);
    localparam int unsigned RW = cnt_width(IMG_H);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          col_last;
    logic          row_last;

    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign last     = col_last && row_last;

    // Step through the raster; row advances on column wrap, both wrap at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end else if (step) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

`ifdef WM_ROI_EN
    assign roi_hit = (int'(col_q) >= ROI_X0) && (int'(col_q) <= ROI_X1) &&
                     (int'(row_q) >= ROI_Y0) && (int'(row_q) <= ROI_Y1);
`else
    assign roi_hit = 1'b1;
`endif

endmodule

// File: rtl/wm_embed.sv
// Watermark embedder: replaces pixel LSBs with the generator's watermark word.
// Optional WM_ROI_EN restricts embedding (and generator stepping) to the ROI.
module wm_embed
    import wm_pkg::*;
#(
    parameter int unsigned PIX_W  = WM_PIX_W,
    parameter int unsigned IMG_W  = WM_IMG_W,
    parameter int unsigned IMG_H  = WM_IMG_H,
    parameter int          ROI_X0 = 0,
    parameter int          ROI_X1 = 255,
    parameter int          ROI_Y0 = 0,
    parameter int          ROI_Y1 = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wm_select,
    output logic          busy,
    output logic          done,
    wm_embed_if.master    bus
);

    wm_state_e        state_q, state_d;
    logic             mode_q, mode_d;
    logic             out_valid_q;
    logic [PIX_W-1:0] pix_out_q;
    logic [PIX_W-1:0] pix_embed;
    logic             in_ready;
    logic             accept;
    logic             out_fire;
    logic             cnt_clear;
    logic             last;
    logic             roi_hit;

    wm_raster_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ROI_X0 (ROI_X0),
        .ROI_X1 (ROI_X1),
        .ROI_Y0 (ROI_Y0),
        .ROI_Y1 (ROI_Y1)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .step    (accept),
        .last    (last),
        .roi_hit (roi_hit)
    );

    // Single output register: accept a new pixel whenever it is empty or draining.
    assign in_ready = (state_q == StEmbed) && (!out_valid_q || bus.pix_out_ready);
    assign accept   = bus.pix_in_valid && in_ready;
    assign out_fire = out_valid_q && bus.pix_out_ready;

    // Substitute the watermark bits into the incoming pixel.
    always_comb begin
        pix_embed = bus.pix_in;
        if (roi_hit) begin
            if (mode_q == WM_MODE_2LSB) begin
                pix_embed[1:0] = bus.wm_data;
            end else begin
                pix_embed[0] = bus.wm_data[0];
            end
        end
    end

    // Next-state, mode latch and done pulse.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_clear = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StEmbed;
                    cnt_clear = 1'b1;
                    mode_d    = wm_select;
                end
            end
            StEmbed: begin
                if (accept && last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_fire) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and mode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= WM_MODE_1LSB;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Output register: load on accept, empty on a drain with nothing new behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pix_out_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            pix_out_q   <= pix_embed;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.pix_in_ready  = in_ready;
    assign bus.pix_out_valid = out_valid_q;
    assign bus.pix_out       = pix_out_q;
    assign bus.wm_advance    = accept && roi_hit;
    assign busy              = (state_q != StIdle);

endmodule
